// File: rtl/hwf_tlul_host.sv
// Fuzzer-driven TL-UL host: turns wait/read/write instructions into single TL-UL
// transactions, one at a time, with a watchdog that aborts wedged transfers.
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  parameter tl_a_user_t TL_A_USER_DEFAULT = '0;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    tl_a_user_t  a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [0:0]  d_sink;
    logic [31:0] d_data;
    tl_d_user_t  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

module hwf_tlul_host #(
  parameter int unsigned TimeoutCycles = 256,
  parameter logic [7:0]  SourceId      = 8'd0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               instr_valid_i,
  output logic               instr_ready_o,
  input  logic [1:0]         instr_op_i,
  input  logic [31:0]        instr_addr_i,
  input  logic [31:0]        instr_data_i,
  output tlul_pkg::tl_h2d_t  tl_o,
  input  tlul_pkg::tl_d2h_t  tl_i,
  output logic               rsp_valid_o,
  output logic [31:0]        rsp_rdata_o,
  output logic               rsp_err_o,
  output logic               hang_o,
  output logic               stray_o
);

  typedef enum logic [1:0] {IDLE, WAIT, REQ, RSP} state_e;

  localparam logic [15:0] TmoLast = 16'(TimeoutCycles - 1);

  state_e      state_q, state_d;
  logic        is_write_q, is_write_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        hang_q, hang_d;
  logic        stray_q, stray_d;

  logic [15:0] tmo_inc;
  logic        tmo_hit;
  logic        timeout;
  logic        unused_tl;

  assign tmo_inc = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_q + 16'd1;
  assign tmo_hit = (tmo_cnt_q >= TmoLast);

  assign unused_tl = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_source,
                       tl_i.d_sink, tl_i.d_user, instr_addr_i[1:0]};

  always_comb begin
    state_d     = state_q;
    is_write_d  = is_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wait_cnt_d  = wait_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    hang_d      = hang_q;
    stray_d     = stray_q | (tl_i.d_valid & (state_q != RSP));
    timeout     = 1'b0;

    case (state_q)
      IDLE: begin
        if (instr_valid_i) begin
          is_write_d = (instr_op_i == 2'd2);
          addr_d     = instr_addr_i[31:2];
          wdata_d    = instr_data_i;
          wait_cnt_d = instr_data_i[7:0];
          if ((instr_op_i == 2'd1) || (instr_op_i == 2'd2)) begin
            state_d   = REQ;
            tmo_cnt_d = '0;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (wait_cnt_q == '0) state_d = IDLE;
        else                  wait_cnt_d = wait_cnt_q - 8'd1;
      end
      REQ: begin
        tmo_cnt_d = tmo_inc;
        if (tmo_hit)              timeout = 1'b1;
        else if (tl_i.a_ready)    state_d = RSP;
      end
      RSP: begin
        tmo_cnt_d = tmo_inc;
        // A response landing on the watchdog's final cycle still completes normally.
        if (tl_i.d_valid) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = is_write_q ? '0 : tl_i.d_data;
          rsp_err_d   = tl_i.d_error;
        end else if (tmo_hit) begin
          timeout = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      state_d     = IDLE;
      rsp_valid_d = 1'b1;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b1;
      hang_d      = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      is_write_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wait_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      hang_q      <= 1'b0;
      stray_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_write_q  <= is_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wait_cnt_q  <= wait_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      hang_q      <= hang_d;
      stray_q     <= stray_d;
    end
  end

  // A channel is decoded purely from registered state, so nothing in tl_i reaches tl_o.
  always_comb begin
    tl_o         = '0;
    tl_o.a_user  = tlul_pkg::TL_A_USER_DEFAULT;
    tl_o.d_ready = 1'b1;
    if (state_q == REQ) begin
      tl_o.a_valid   = 1'b1;
      tl_o.a_opcode  = is_write_q ? tlul_pkg::PutFullData : tlul_pkg::Get;
      tl_o.a_size    = 2'd2;
      tl_o.a_mask    = 4'hF;
      tl_o.a_source  = SourceId;
      tl_o.a_address = {addr_q, 2'b00};
      tl_o.a_data    = is_write_q ? wdata_q : '0;
    end
  end

  assign instr_ready_o = (state_q == IDLE);
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign hang_o        = hang_q;
  assign stray_o       = stray_q;

endmodule

// File: doc/hwf_tlul_host.md
# hwf_tlul_host

Fuzzer-driven TL-UL host that sits directly upstream of the AES testbench's `tl_i`/`tl_o` port. It accepts a stream of decoded fuzz instructions (wait, read, write) over a valid/ready handshake and turns each one into a single TL-UL transaction. It issues at most one transaction at a time and returns one response record per read or write. A timeout watchdog guarantees forward progress, so a wedged DUT can never stall the fuzz harness.

## Interface
- `TimeoutCycles`, 256: cycles an instruction may spend in REQ+RSP before it is aborted; range 2..65535.
- `SourceId`, 0: constant value driven on `a_source`.
- `clk_i` in 1: sole clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `instr_valid_i` in 1: instruction valid.
- `instr_ready_o` out 1: instruction accepted when high together with valid.
- `instr_op_i` in 2: operation. 0 = WAIT, 1 = READ, 2 = WRITE, 3 = treated as WAIT.
- `instr_addr_i` in 32: byte address; bits [1:0] are ignored.
- `instr_data_i` in 32: write data; for WAIT, bits [7:0] give the wait length.
- `tl_o` out `tlul_pkg::tl_h2d_t`: TL-UL A channel and `d_ready`.
- `tl_i` in `tlul_pkg::tl_d2h_t`: TL-UL D channel and `a_ready`.
- `rsp_valid_o` out 1: one-cycle pulse marking response completion.
- `rsp_rdata_o` out 32: captured `d_data` for READ; 0 for WRITE and for timeouts.
- `rsp_err_o` out 1: `d_error` was set, or the transaction timed out.
- `hang_o` out 1: sticky; set when any timeout occurs.
- `stray_o` out 1: sticky; set when a D response arrives outside RSP.

## Operation
- States: IDLE, WAIT, REQ, RSP.
- IDLE
  - `instr_ready_o = 1` in IDLE only.
  - On handshake, latch op, address, data and wait length.
  - WAIT op: go to WAIT with the counter loaded from data[7:0].
  - READ or WRITE op: go to REQ with the timeout counter cleared.
- WAIT
  - Decrement each cycle; return to IDLE on the cycle the counter reads 0.
  - A length of 0 returns to IDLE on the next cycle.
  - WAIT produces no response.
- REQ
  - `a_valid = 1`.
  - `a_opcode`: Get (4) for READ, PutFullData (0) for WRITE.
  - `a_size = 2`, `a_mask = 4'hF`, `a_param = 0`, `a_source = SourceId`, `a_address = {addr[31:2], 2'b00}`.
  - `a_data` = latched data for WRITE, 0 for READ. `a_user` = `tlul_pkg` default.
  - All A fields are held stable while `a_valid` is high.
  - `a_valid & a_ready`: go to RSP.
- RSP
  - On `d_valid`: capture `d_data` (READ only) and `d_error`, pulse `rsp_valid_o` the following cycle, and return to IDLE.
- Timeout
  - The counter increments in REQ and RSP and saturates.
  - When it reaches `TimeoutCycles - 1` with no completion, the block: drops `a_valid` (intentional TL-UL deviation for the harness), sets `hang_o`, pulses `rsp_valid_o` with `rsp_err_o = 1` and `rsp_rdata_o = 0`, and returns to IDLE.
- `d_ready` is tied to 1 in all states.
- A `d_valid` seen in any state other than RSP is discarded and sets `stray_o`. This covers late responses after a timeout.
- Sticky flags clear only on reset.

## Timing
- Reset values:
  - State = IDLE.
  - `instr_ready_o = 1`.
  - `a_valid = 0`, all A fields = 0.
  - `d_ready = 1`.
  - `rsp_valid_o = 0`, `rsp_rdata_o = 0`, `rsp_err_o = 0`.
  - `hang_o = 0`, `stray_o = 0`.
- All outputs are registered or decoded from state; there is no combinational path from `tl_i` to `tl_o`.
- Minimum READ/WRITE latency:
  - Accept at cycle 0.
  - `a_valid` high at cycle 1.
  - `a_ready` in cycle 1 gives RSP at cycle 2.
  - `d_valid` in cycle 2 gives `rsp_valid_o` at cycle 3.
  - `instr_ready_o` is high again at cycle 3.
- WAIT of length N occupies N+1 cycles from acceptance until `instr_ready_o` returns high.
- `d_valid` in the same cycle the timeout fires: the response wins, `rsp_err_o = d_error`, and `hang_o` is not set.
- Reset asserted mid-transaction: the block returns to reset values immediately, with no response pulse. Responses arriving after reset set `stray_o`.
- `rsp_valid_o` is never high on two consecutive cycles.

## Test plan
- Read: op=1, addr=0x0000_0087; DUT `a_ready=1`, then `d_valid` next cycle with `d_data=0xDEADBEEF`.
  - Required: `a_opcode=4`, `a_address=0x84`, `rsp_valid_o` at cycle 3, `rsp_rdata_o=0xDEADBEEF`, `rsp_err_o=0`.
- Write with backpressure: op=2, data=0x1234_5678; `a_ready` held low 5 cycles.
  - Required: A fields stable for all 6 cycles of `a_valid`, `a_mask=0xF`, `a_data=0x12345678`, `rsp_rdata_o=0`.
- Error response: `d_error=1` on a READ.
  - Required: `rsp_err_o=1` and the captured `d_data` is returned.
- WAIT: op=0 with data[7:0]=0 and, separately, data[7:0]=10.
  - Required: `instr_ready_o` low for exactly 1 and 11 cycles respectively; no `rsp_valid_o`; `a_valid` stays 0.
- Timeout: `TimeoutCycles=8`, `a_ready` stuck at 0.
  - Required: `a_valid` drops after 8 cycles, `hang_o=1`, `rsp_err_o=1`.
  - A later `d_valid` sets `stray_o`.
  - The next instruction completes normally.
- Reset mid-RSP: assert `rst_ni=0` while in RSP.
  - Required: all outputs return to reset values asynchronously; no `rsp_valid_o` is generated.
